// File: rtl/bsg_manycore_io_credit_bridge.sv
// Host-side endpoint on one IO-row p-port: credit-metered request path, buffered
// response path, and a fence that waits for every outstanding request to be answered.
module bsg_manycore_io_credit_bridge #(
   parameter int unsigned fwd_width_p       = 32,
   parameter int unsigned rev_width_p       = 32,
   parameter int unsigned max_out_credits_p = 16,
   parameter int unsigned rev_fifo_els_p    = 4,
   localparam int unsigned credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,

   input  logic                       host_v_i,
   input  logic [fwd_width_p-1:0]     host_data_i,
   output logic                       host_ready_o,

   output logic                       fwd_v_o,
   output logic [fwd_width_p-1:0]     fwd_data_o,
   input  logic                       fwd_ready_i,

   input  logic                       rev_v_i,
   input  logic [rev_width_p-1:0]     rev_data_i,
   output logic                       rev_ready_o,

   output logic                       resp_v_o,
   output logic [rev_width_p-1:0]     resp_data_o,
   input  logic                       resp_ready_i,

   input  logic                       fence_i,
   output logic                       fence_done_o,
   output logic [credit_width_lp-1:0] out_credits_o,
   output logic                       credit_err_o
);

   localparam int unsigned rev_ptr_w_lp = $clog2(rev_fifo_els_p);
   localparam int unsigned rev_cnt_w_lp = $clog2(rev_fifo_els_p + 1);
   localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
   localparam logic [rev_ptr_w_lp-1:0]    rev_last_lp    = rev_ptr_w_lp'(rev_fifo_els_p - 1);
   localparam logic [rev_cnt_w_lp-1:0]    rev_full_lp    = rev_cnt_w_lp'(rev_fifo_els_p);

   typedef enum logic {READY_S, FENCE_S} state_e;

   state_e                     state_q, state_d;
   logic                       fence_done_q, fence_done_d;
   logic [credit_width_lp-1:0] out_credits_q, out_credits_d;
   logic                       credit_err_q, credit_err_d;

   logic [1:0]                 fwd_cnt_q, fwd_cnt_d;
   logic [fwd_width_p-1:0]     fwd_head_q, fwd_head_d;
   logic [fwd_width_p-1:0]     fwd_tail_q, fwd_tail_d;

   logic [rev_width_p-1:0]     rev_mem_q [rev_fifo_els_p];
   logic [rev_width_p-1:0]     rev_mem_d [rev_fifo_els_p];
   logic [rev_ptr_w_lp-1:0]    rev_wr_ptr_q, rev_wr_ptr_d;
   logic [rev_ptr_w_lp-1:0]    rev_rd_ptr_q, rev_rd_ptr_d;
   logic [rev_cnt_w_lp-1:0]    rev_cnt_q, rev_cnt_d;

   logic host_acc, fwd_deq, rev_acc, resp_deq;
   logic credit_at_max, credit_inc;

   // A credit is reserved at accept, so packets already queued count against the budget.
   assign host_ready_o = (state_q == READY_S) && (fwd_cnt_q != 2'd2)
                         && (out_credits_q > credit_width_lp'(fwd_cnt_q));
   assign fwd_v_o      = (fwd_cnt_q != 2'd0);
   assign fwd_data_o   = fwd_head_q;
   assign rev_ready_o  = (rev_cnt_q != rev_full_lp);
   assign resp_v_o     = (rev_cnt_q != '0);
   assign resp_data_o  = rev_mem_q[rev_rd_ptr_q];
   assign fence_done_o  = fence_done_q;
   assign out_credits_o = out_credits_q;
   assign credit_err_o  = credit_err_q;

   assign host_acc      = host_v_i & host_ready_o;
   assign fwd_deq       = fwd_v_o & fwd_ready_i;
   assign rev_acc       = rev_v_i & rev_ready_o;
   assign resp_deq      = resp_v_o & resp_ready_i;
   assign credit_at_max = (out_credits_q == max_credits_lp);
   assign credit_inc    = rev_acc & ~credit_at_max;

   // Two-entry forward queue: head drives the router directly, tail is the skid slot.
   always_comb begin
      fwd_cnt_d  = fwd_cnt_q;
      fwd_head_d = fwd_head_q;
      fwd_tail_d = fwd_tail_q;
      case (fwd_cnt_q)
         2'd0: begin
            if (host_acc) begin
               fwd_head_d = host_data_i;
               fwd_cnt_d  = 2'd1;
            end
         end
         2'd1: begin
            if (host_acc && fwd_deq) begin
               fwd_head_d = host_data_i;
            end else if (host_acc) begin
               fwd_tail_d = host_data_i;
               fwd_cnt_d  = 2'd2;
            end else if (fwd_deq) begin
               fwd_cnt_d  = 2'd0;
            end
         end
         default: begin
            if (fwd_deq) begin
               fwd_head_d = fwd_tail_q;
               fwd_cnt_d  = 2'd1;
            end
         end
      endcase
   end

   // Credit counter; a return with nothing outstanding is flagged instead of counted.
   always_comb begin
      out_credits_d = out_credits_q;
      credit_err_d  = credit_err_q | (rev_acc & credit_at_max);
      case ({credit_inc, host_acc})
         2'b10:   out_credits_d = out_credits_q + credit_width_lp'(1);
         2'b01:   out_credits_d = out_credits_q - credit_width_lp'(1);
         default: out_credits_d = out_credits_q;
      endcase
   end

   always_comb begin
      rev_mem_d    = rev_mem_q;
      rev_wr_ptr_d = rev_wr_ptr_q;
      rev_rd_ptr_d = rev_rd_ptr_q;
      rev_cnt_d    = rev_cnt_q;
      if (rev_acc) begin
         rev_mem_d[rev_wr_ptr_q] = rev_data_i;
         rev_wr_ptr_d = (rev_wr_ptr_q == rev_last_lp) ? '0 : rev_wr_ptr_q + rev_ptr_w_lp'(1);
      end
      if (resp_deq) begin
         rev_rd_ptr_d = (rev_rd_ptr_q == rev_last_lp) ? '0 : rev_rd_ptr_q + rev_ptr_w_lp'(1);
      end
      case ({rev_acc, resp_deq})
         2'b10:   rev_cnt_d = rev_cnt_q + rev_cnt_w_lp'(1);
         2'b01:   rev_cnt_d = rev_cnt_q - rev_cnt_w_lp'(1);
         default: rev_cnt_d = rev_cnt_q;
      endcase
   end

   // Fence completes on next-cycle values so the pulse lands right after the last return.
   always_comb begin
      state_d      = state_q;
      fence_done_d = 1'b0;
      case (state_q)
         READY_S: begin
            if (fence_i) state_d = FENCE_S;
         end
         FENCE_S: begin
            if ((out_credits_d == max_credits_lp) && (fwd_cnt_d == 2'd0)) begin
               state_d      = READY_S;
               fence_done_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= READY_S;
         fence_done_q  <= 1'b0;
         out_credits_q <= max_credits_lp;
         credit_err_q  <= 1'b0;
         fwd_cnt_q     <= 2'd0;
         fwd_head_q    <= '0;
         fwd_tail_q    <= '0;
         rev_wr_ptr_q  <= '0;
         rev_rd_ptr_q  <= '0;
         rev_cnt_q     <= '0;
         for (int i = 0; i < int'(rev_fifo_els_p); i++) rev_mem_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         fence_done_q  <= fence_done_d;
         out_credits_q <= out_credits_d;
         credit_err_q  <= credit_err_d;
         fwd_cnt_q     <= fwd_cnt_d;
         fwd_head_q    <= fwd_head_d;
         fwd_tail_q    <= fwd_tail_d;
         rev_wr_ptr_q  <= rev_wr_ptr_d;
         rev_rd_ptr_q  <= rev_rd_ptr_d;
         rev_cnt_q     <= rev_cnt_d;
         rev_mem_q     <= rev_mem_d;
      end
   end

endmodule

// File: tb/tb_bsg_manycore_io_credit_bridge.sv
// Scoreboard bench for bsg_manycore_io_credit_bridge with 4 credits and a 4-deep response buffer.
module tb_bsg_manycore_io_credit_bridge;

   localparam int unsigned FW = 16;
   localparam int unsigned RW = 16;
   localparam int unsigned CW = 3;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          host_v_i;
   logic [FW-1:0] host_data_i;
   logic          host_ready_o;
   logic          fwd_v_o;
   logic [FW-1:0] fwd_data_o;
   logic          fwd_ready_i;
   logic          rev_v_i;
   logic [RW-1:0] rev_data_i;
   logic          rev_ready_o;
   logic          resp_v_o;
   logic [RW-1:0] resp_data_o;
   logic          resp_ready_i;
   logic          fence_i;
   logic          fence_done_o;
   logic [CW-1:0] out_credits_o;
   logic          credit_err_o;

   bsg_manycore_io_credit_bridge #(
      .fwd_width_p(FW), .rev_width_p(RW), .max_out_credits_p(4), .rev_fifo_els_p(4)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .host_v_i(host_v_i), .host_data_i(host_data_i), .host_ready_o(host_ready_o),
      .fwd_v_o(fwd_v_o), .fwd_data_o(fwd_data_o), .fwd_ready_i(fwd_ready_i),
      .rev_v_i(rev_v_i), .rev_data_i(rev_data_i), .rev_ready_o(rev_ready_o),
      .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_ready_i(resp_ready_i),
      .fence_i(fence_i), .fence_done_o(fence_done_o),
      .out_credits_o(out_credits_o), .credit_err_o(credit_err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;
   logic [FW-1:0] fwd_q [$];
   logic [RW-1:0] resp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: every transfer the DUT presents is matched against the scoreboard queues.
   always @(negedge clk_i) begin
      if (fwd_v_o && fwd_ready_i) begin
         if (fwd_q.size() == 0) begin
            n_checks++;
            $display("FAIL fwd_unexpected: got %0h expected none", fwd_data_o);
         end else check("fwd_data", 32'(fwd_data_o), 32'(fwd_q.pop_front()));
      end
      if (resp_v_o && resp_ready_i) begin
         if (resp_q.size() == 0) begin
            n_checks++;
            $display("FAIL resp_unexpected: got %0h expected none", resp_data_o);
         end else check("resp_data", 32'(resp_data_o), 32'(resp_q.pop_front()));
      end
   end

   task automatic send(input logic [FW-1:0] d);
      bit done = 0;
      host_v_i = 1'b1;
      host_data_i = d;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk_i);
         if (host_ready_o) begin
            fwd_q.push_back(d);
            done = 1;
         end
         tick();
      end
      host_v_i = 1'b0;
      if (!done) check("send_timeout", 32'(0), 32'(1));
   endtask

   task automatic ret(input logic [RW-1:0] d);
      bit done = 0;
      rev_v_i = 1'b1;
      rev_data_i = d;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk_i);
         if (rev_ready_o) begin
            resp_q.push_back(d);
            done = 1;
         end
         tick();
      end
      rev_v_i = 1'b0;
      if (!done) check("ret_timeout", 32'(0), 32'(1));
   endtask

   initial begin
      repeat (20000) @(posedge clk_i);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int acc;
      bit stable;
      reset_i = 1'b1; host_v_i = 0; host_data_i = '0; fwd_ready_i = 1; rev_v_i = 0;
      rev_data_i = '0; resp_ready_i = 1; fence_i = 0;
      repeat (2) tick();
      reset_i = 1'b0;
      tick();
      check("rst_credits", 32'(out_credits_o), 32'd4);
      check("rst_host_ready", 32'(host_ready_o), 32'd1);
      check("rst_fwd_v", 32'(fwd_v_o), 32'd0);
      check("rst_resp_v", 32'(resp_v_o), 32'd0);
      check("rst_rev_ready", 32'(rev_ready_o), 32'd1);
      check("rst_fence_done", 32'(fence_done_o), 32'd0);
      check("rst_err", 32'(credit_err_o), 32'd0);

      // Four requests exhaust the credits; one return restores one.
      for (int k = 1; k <= 4; k++) begin
         send(FW'(16'h1000 + k));
         check("credits_dec", 32'(out_credits_o), 32'(4 - k));
      end
      check("no_credit_ready", 32'(host_ready_o), 32'd0);
      ret(16'h5001);
      check("credit_back", 32'(out_credits_o), 32'd1);
      check("ready_back", 32'(host_ready_o), 32'd1);
      ret(16'h5002);
      check("credits_two", 32'(out_credits_o), 32'd2);

      // Simultaneous host accept and return at two credits.
      host_v_i = 1; host_data_i = 16'h1100; rev_v_i = 1; rev_data_i = 16'h5003;
      @(negedge clk_i);
      check("sim_host_ready", 32'(host_ready_o), 32'd1);
      check("sim_rev_ready", 32'(rev_ready_o), 32'd1);
      fwd_q.push_back(16'h1100);
      resp_q.push_back(16'h5003);
      tick();
      host_v_i = 0; rev_v_i = 0;
      check("sim_credits", 32'(out_credits_o), 32'd2);

      // Fence with three outstanding.
      send(16'h1101);
      check("pre_fence_credits", 32'(out_credits_o), 32'd1);
      fence_i = 1;
      tick();
      fence_i = 0;
      check("fence_blocks", 32'(host_ready_o), 32'd0);
      ret(16'h5004);
      check("fence_wait1", 32'(fence_done_o), 32'd0);
      ret(16'h5005);
      check("fence_wait2", 32'(fence_done_o), 32'd0);
      ret(16'h5006);
      check("fence_done", 32'(fence_done_o), 32'd1);
      check("fence_credits", 32'(out_credits_o), 32'd4);
      check("fence_ready", 32'(host_ready_o), 32'd1);
      tick();
      check("fence_pulse_end", 32'(fence_done_o), 32'd0);

      // Fence while idle completes one cycle after entry.
      fence_i = 1;
      tick();
      fence_i = 0;
      check("idle_fence_in", 32'(fence_done_o), 32'd0);
      check("idle_fence_block", 32'(host_ready_o), 32'd0);
      tick();
      check("idle_fence_done", 32'(fence_done_o), 32'd1);
      check("idle_fence_ready", 32'(host_ready_o), 32'd1);
      tick();
      check("idle_fence_end", 32'(fence_done_o), 32'd0);

      // Router stalled: only two requests fit, head held stable.
      fwd_ready_i = 0; host_v_i = 1; host_data_i = 16'h2000; acc = 0; stable = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (fwd_v_o && fwd_data_o != 16'h2000) stable = 0;
         if (host_ready_o) begin
            fwd_q.push_back(host_data_i);
            acc++;
            tick();
            host_data_i = host_data_i + 16'd1;
         end else tick();
      end
      host_v_i = 0;
      check("stall_accepts", 32'(acc), 32'd2);
      check("stall_stable", 32'(stable), 32'd1);
      check("stall_credits", 32'(out_credits_o), 32'd2);
      fwd_ready_i = 1;
      repeat (4) tick();
      check("stall_drained", 32'(fwd_q.size()), 32'd0);
      ret(16'h5007);
      ret(16'h5008);
      check("stall_restored", 32'(out_credits_o), 32'd4);

      // Response buffer fills at four; extra returns arrive at full credits.
      for (int k = 0; k < 4; k++) send(FW'(16'h1200 + k));
      resp_ready_i = 0; rev_v_i = 1; rev_data_i = 16'h3001; acc = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         if (rev_ready_o) begin
            resp_q.push_back(rev_data_i);
            acc++;
            tick();
            rev_data_i = rev_data_i + 16'd1;
         end else tick();
      end
      check("fill_accepts", 32'(acc), 32'd4);
      check("fill_rev_ready", 32'(rev_ready_o), 32'd0);
      check("fill_credits", 32'(out_credits_o), 32'd4);
      check("fill_err", 32'(credit_err_o), 32'd0);
      resp_ready_i = 1;
      @(negedge clk_i);
      check("full_deq_no_accept", 32'(rev_ready_o), 32'd0);
      tick();
      for (int i = 0; i < 10 && acc < 6; i++) begin
         @(negedge clk_i);
         if (rev_ready_o) begin
            resp_q.push_back(rev_data_i);
            acc++;
            tick();
            rev_data_i = rev_data_i + 16'd1;
         end else tick();
      end
      rev_v_i = 0;
      check("over_accepts", 32'(acc), 32'd6);
      repeat (8) tick();
      check("over_drained", 32'(resp_q.size()), 32'd0);
      check("err_sticky", 32'(credit_err_o), 32'd1);
      check("err_credits", 32'(out_credits_o), 32'd4);

      // Asynchronous reset with both paths holding packets.
      fwd_ready_i = 0; resp_ready_i = 0;
      send(16'h1300);
      send(16'h1301);
      ret(16'h5100);
      check("burst_fwd_v", 32'(fwd_v_o), 32'd1);
      check("burst_resp_v", 32'(resp_v_o), 32'd1);
      check("burst_credits", 32'(out_credits_o), 32'd3);
      @(posedge clk_i);
      #3 reset_i = 1'b1;
      #1;
      check("arst_fwd_v", 32'(fwd_v_o), 32'd0);
      check("arst_resp_v", 32'(resp_v_o), 32'd0);
      check("arst_credits", 32'(out_credits_o), 32'd4);
      check("arst_err", 32'(credit_err_o), 32'd0);
      check("arst_fence_done", 32'(fence_done_o), 32'd0);
      fwd_q.delete();
      resp_q.delete();
      tick();
      reset_i = 1'b0;
      fwd_ready_i = 1; resp_ready_i = 1;
      tick();
      send(16'h1400);
      ret(16'h5200);
      repeat (3) tick();
      check("post_fwd_empty", 32'(fwd_q.size()), 32'd0);
      check("post_resp_empty", 32'(resp_q.size()), 32'd0);
      check("post_credits", 32'(out_credits_o), 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
